// File: rtl/nonlinear_round_engine_if.sv
// Job, round-key and result handshake bundle for nonlinear_round_engine.
// The engine connects through the slave modport; the job source / key store uses master.
interface nonlinear_round_engine_if #(
  parameter int N   = 128,
  parameter int RCW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [RCW-1:0] in_rounds;
  logic           mode_enc_dec;
  logic [2:0]     alg_mode;
  logic           rk_req;
  logic [RCW-1:0] rk_idx;
  logic           rk_valid;
  logic [N-1:0]   rk_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           busy;
  logic           cfg_err;

  modport slave (
    input  in_valid, in_data, in_rounds, mode_enc_dec, alg_mode, rk_valid, rk_data, out_ready,
    output in_ready, rk_req, rk_idx, out_valid, out_data, busy, cfg_err
  );

  modport master (
    output in_valid, in_data, in_rounds, mode_enc_dec, alg_mode, rk_valid, rk_data, out_ready,
    input  in_ready, rk_req, rk_idx, out_valid, out_data, busy, cfg_err
  );
endinterface

// File: rtl/nonlinear_round_engine.sv
// Iterated non-linear round engine: R rounds over N/128 independent 128-bit lanes, one fetched
// round key per round. Define NLRE_ABORT_EN to add the abort input.
module nonlinear_round_engine #(
  parameter int N          = 128,
  parameter int ALG_MODE   = 2,
  parameter int ROUNDS_MAX = 16,
  parameter int RCW        = $clog2(ROUNDS_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
`ifdef NLRE_ABORT_EN
  input  logic abort,
`endif
  nonlinear_round_engine_if.slave bus
);
  localparam int LANES    = N / 128;
  localparam int MC_SHIFT = (ALG_MODE == 4) ? 24 : (ALG_MODE == 2) ? 32 : 16;
  localparam logic [RCW-1:0] R_MAX = RCW'(ROUNDS_MAX);

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] SBOX_INV [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                           4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [127:0] sub_layer(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 32; i++)
      y[i*4 +: 4] = inv ? SBOX_INV[x[i*4 +: 4]] : SBOX[x[i*4 +: 4]];
    return y;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x);
    return x ^ (x << MC_SHIFT);
  endfunction

  // x ^ (x << s) is lower-triangular, so its inverse is the truncated series sum(x << k*s).
  function automatic logic [127:0] unmix(input logic [127:0] x);
    logic [127:0] y;
    y = x;
    for (int k = 1; k * MC_SHIFT < 128; k++)
      y = y ^ (x << (k * MC_SHIFT));
    return y;
  endfunction

  // Keyless SPECK-style ARX step on the two 64-bit halves of a lane.
  function automatic logic [127:0] arx(input logic [127:0] x, input logic inv);
    logic [63:0] a, b;
    a = x[127:64];
    b = x[63:0];
    if (!inv) begin
      a = {a[7:0], a[63:8]} + b;
      b = {b[60:0], b[63:61]} ^ a;
    end else begin
      b = b ^ a;
      b = {b[2:0], b[63:3]};
      a = a - b;
      a = {a[55:0], a[63:56]};
    end
    return {a, b};
  endfunction

  function automatic logic [127:0] round_lane(input logic [127:0] lane, input logic [127:0] key,
                                              input logic dec, input logic [2:0] alg);
    logic [127:0] t;
    t = '0;
    if (!dec) begin
      case (alg)
        3'b000:  t = sub_layer(lane, 1'b0);
        3'b011:  t = arx(lane, 1'b0);
        default: t = mix(sub_layer(lane, 1'b0));
      endcase
      t = t ^ key;
    end else begin
      case (alg)
        3'b000:  t = sub_layer(lane ^ key, 1'b1);
        3'b011:  t = arx(lane ^ key, 1'b1);
        default: t = sub_layer(unmix(lane ^ key), 1'b1);
      endcase
    end
    return t;
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   st_q, st_f;
  logic [RCW-1:0] rnd_q, rounds_q, r_accept;
  logic           dec_q, cfg_err_q, clamp, abort_hit, last_key;
  logic [2:0]     alg_q;

  assign clamp    = bus.in_rounds > R_MAX;
  assign r_accept = clamp ? R_MAX : bus.in_rounds;
  assign last_key = bus.rk_valid && (rnd_q == rounds_q - 1'b1);

`ifdef NLRE_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign st_f[l*128 +: 128] = round_lane(st_q[l*128 +: 128], bus.rk_data[l*128 +: 128],
                                           dec_q, alg_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = (r_accept == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_key)     state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.rk_req    = 1'b0;
    bus.rk_idx    = '0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      S_IDLE: bus.in_ready = 1'b1;
      S_RUN: begin
        bus.rk_req = 1'b1;
        bus.busy   = 1'b1;
        bus.rk_idx = dec_q ? (rounds_q - 1'b1 - rnd_q) : rnd_q;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the wide state register is reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '0;
      rnd_q     <= '0;
      rounds_q  <= '0;
      dec_q     <= 1'b0;
      alg_q     <= 3'b000;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (state_q == S_IDLE && bus.in_valid) begin
        st_q      <= bus.in_data;
        rounds_q  <= r_accept;
        rnd_q     <= '0;
        dec_q     <= bus.mode_enc_dec;
        alg_q     <= bus.alg_mode;
        cfg_err_q <= clamp;
      end else if (state_q == S_RUN && bus.rk_valid) begin
        st_q  <= st_f;
        rnd_q <= rnd_q + 1'b1;
      end
    end
  end

  assign bus.out_data = st_q;
  assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_nonlinear_round_engine.sv
// Self-checking bench for nonlinear_round_engine: a 128-bit and a 256-bit instance driven from one
// job/key-store model; results compared against a lane-level reference of the round rules.
module tb_nonlinear_round_engine;
  localparam int RMAX   = 16;
  localparam int RCW    = $clog2(RMAX + 1);
  localparam int MCS    = 32;     // mix shift for ALG_MODE = 2 (spn32)
  localparam int BUDGET = 2000;

  localparam int SBOX_T [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nonlinear_round_engine_if #(.N(128), .RCW(RCW)) if_a ();
  nonlinear_round_engine_if #(.N(256), .RCW(RCW)) if_b ();

  logic           sel;
  logic           d_in_valid, d_dec, d_rk_valid, d_out_ready;
  logic [255:0]   d_in_data, d_rk_data;
  logic [RCW-1:0] d_rounds;
  logic [2:0]     d_alg;

  assign if_a.in_valid     = d_in_valid & ~sel;
  assign if_a.in_data      = d_in_data[127:0];
  assign if_a.in_rounds    = d_rounds;
  assign if_a.mode_enc_dec = d_dec;
  assign if_a.alg_mode     = d_alg;
  assign if_a.rk_valid     = d_rk_valid & ~sel;
  assign if_a.rk_data      = d_rk_data[127:0];
  assign if_a.out_ready    = d_out_ready & ~sel;
  assign if_b.in_valid     = d_in_valid & sel;
  assign if_b.in_data      = d_in_data;
  assign if_b.in_rounds    = d_rounds;
  assign if_b.mode_enc_dec = d_dec;
  assign if_b.alg_mode     = d_alg;
  assign if_b.rk_valid     = d_rk_valid & sel;
  assign if_b.rk_data      = d_rk_data;
  assign if_b.out_ready    = d_out_ready & sel;

`ifdef NLRE_ABORT_EN
  logic d_abort;
  logic abort_a, abort_b;
  assign abort_a = d_abort & ~sel;
  assign abort_b = d_abort & sel;
`endif

  nonlinear_round_engine #(.N(128), .ALG_MODE(2), .ROUNDS_MAX(RMAX)) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef NLRE_ABORT_EN
    .abort(abort_a),
`endif
    .bus(if_a)
  );

  nonlinear_round_engine #(.N(256), .ALG_MODE(2), .ROUNDS_MAX(RMAX)) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef NLRE_ABORT_EN
    .abort(abort_b),
`endif
    .bus(if_b)
  );

  logic           o_in_ready, o_rk_req, o_out_valid, o_busy, o_cfg_err;
  logic [RCW-1:0] o_rk_idx;
  logic [255:0]   o_out_data;
  assign o_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
  assign o_rk_req    = sel ? if_b.rk_req    : if_a.rk_req;
  assign o_rk_idx    = sel ? if_b.rk_idx    : if_a.rk_idx;
  assign o_out_valid = sel ? if_b.out_valid : if_a.out_valid;
  assign o_busy      = sel ? if_b.busy      : if_a.busy;
  assign o_cfg_err   = sel ? if_b.cfg_err   : if_a.cfg_err;
  assign o_out_data  = sel ? if_b.out_data  : {128'b0, if_a.out_data};

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] keys [RMAX];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: round rules in plain arithmetic ----------------
  function automatic logic [127:0] ref_sub(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      int v, o;
      v = int'(x[i*4 +: 4]);
      o = SBOX_T[v];
      if (inv) for (int j = 0; j < 16; j++) if (SBOX_T[j] == v) o = j;
      y[i*4 +: 4] = o[3:0];
    end
    return y;
  endfunction

  function automatic logic [127:0] ref_arx(input logic [127:0] x, input bit inv);
    longint unsigned a, b;
    a = x[127:64];
    b = x[63:0];
    if (!inv) begin
      a = ((a >> 8) | (a << 56)) + b;
      b = ((b << 3) | (b >> 61)) ^ a;
    end else begin
      b = b ^ a;
      b = (b >> 3) | (b << 61);
      a = a - b;
      a = (a << 8) | (a >> 56);
    end
    return {a, b};
  endfunction

  // Inverse mix by fixed-point iteration: each pass settles MCS more bits.
  function automatic logic [127:0] ref_unmix(input logic [127:0] x);
    logic [127:0] y;
    y = x;
    repeat (8) y = x ^ (y << MCS);
    return y;
  endfunction

  function automatic logic [127:0] ref_lane(input logic [127:0] l, input logic [127:0] k,
                                            input bit dec, input logic [2:0] alg);
    if (!dec) begin
      if (alg == 3'b000) return ref_sub(l, 0) ^ k;
      if (alg == 3'b011) return ref_arx(l, 0) ^ k;
      return (ref_sub(l, 0) ^ (ref_sub(l, 0) << MCS)) ^ k;
    end
    if (alg == 3'b000) return ref_sub(l ^ k, 1);
    if (alg == 3'b011) return ref_arx(l ^ k, 1);
    return ref_sub(ref_unmix(l ^ k), 1);
  endfunction

  function automatic logic [255:0] ref_job(input logic [255:0] d, input int r, input bit dec,
                                           input logic [2:0] alg, input int lanes);
    logic [255:0] s;
    s = d;
    for (int i = 0; i < r; i++) begin
      int idx;
      idx = dec ? r - 1 - i : i;
      for (int l = 0; l < lanes; l++)
        s[l*128 +: 128] = ref_lane(s[l*128 +: 128], keys[idx][l*128 +: 128], dec, alg);
    end
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, o_in_ready, 1);
    check({tag, "_rk_req"}, o_rk_req, 0);
    check({tag, "_rk_idx"}, o_rk_idx, 0);
    check({tag, "_out_valid"}, o_out_valid, 0);
    check({tag, "_out_data"}, o_out_data, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_cfg_err"}, o_cfg_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d_in_valid = 0; d_rk_valid = 0; d_out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one job from accept to out handshake; caller and task both sit at a falling edge.
  task automatic run_job(input bit wide, input logic [255:0] data, input int rounds, input bit dec,
                         input logic [2:0] alg, input int stall, input int hold, input bit iv_in_done,
                         output logic [255:0] result);
    int r, c, n_keys, waitc;
    logic [255:0] d_eff, exp, held;
    r = (rounds > RMAX) ? RMAX : rounds;
    d_eff = wide ? data : {128'b0, data[127:0]};
    n_keys = 0;
    waitc = 0;
    sel = wide;
    #1;
    check("in_ready_idle", o_in_ready, 1);
    d_in_valid = 1; d_in_data = d_eff; d_rounds = RCW'(rounds); d_dec = dec; d_alg = alg;
    @(negedge clk);
    d_in_valid = 0; d_in_data = rand256(); d_dec = ~dec; d_alg = ~alg;
    c = 1;
    check("cfg_err_pulse", o_cfg_err, rounds > RMAX);
    while (!o_out_valid && c < BUDGET) begin
      if (c == 2) check("cfg_err_drop", o_cfg_err, 0);
      if (o_rk_req) begin
        check("rk_idx", o_rk_idx, dec ? r - 1 - n_keys : n_keys);
        if (waitc < stall) begin
          d_rk_valid = 0;
          waitc++;
        end else begin
          d_rk_valid = 1;
          d_rk_data = keys[o_rk_idx];
          n_keys++;
          waitc = 0;
        end
      end else begin
        d_rk_valid = 0;
      end
      @(negedge clk);
      c++;
    end
    d_rk_valid = 0;
    check("latency", c, r * (stall + 1) + 1);
    check("keys_used", n_keys, r);
    check("rk_req_done", o_rk_req, 0);
    exp = ref_job(d_eff, r, dec, alg, wide ? 2 : 1);
    check("out_data", o_out_data, exp);
    result = o_out_data;
    held = o_out_data;
    if (c >= BUDGET) begin
      do_reset();
    end else begin
      if (iv_in_done) begin
        d_in_valid = 1; d_in_data = rand256(); d_rounds = 1;
      end
      for (int h = 0; h < hold; h++) begin
        check("in_ready_done", o_in_ready, 0);
        @(negedge clk);
        check("out_valid_hold", o_out_valid, 1);
        check("out_data_hold", o_out_data, held);
      end
      d_out_ready = 1;
      @(negedge clk);
      d_out_ready = 0;
      check("out_valid_drop", o_out_valid, 0);
      check("in_ready_back", o_in_ready, 1);
      check("out_data_kept", o_out_data, held);
      check("busy_idle", o_busy, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] pt, ct, back;
    logic [2:0]   algs [3] = '{3'b000, 3'b011, 3'b001};
    sel = 0; d_in_valid = 0; d_in_data = '0; d_rounds = '0; d_dec = 0; d_alg = '0;
    d_rk_valid = 0; d_rk_data = '0; d_out_ready = 0;
`ifdef NLRE_ABORT_EN
    d_abort = 0;
`endif
    for (int i = 0; i < RMAX; i++) keys[i] = rand256();
    rst = 1;
    repeat (3) @(negedge clk);
    sel = 0; #1; check_reset("rst_n128");
    sel = 1; #1; check_reset("rst_n256");
    rst = 0;
    @(negedge clk);

    // R = 0 passes the input straight through
    pt = 256'h00112233445566778899AABBCCDDEEFF;
    run_job(0, pt, 0, 0, 3'b000, 0, 0, 0, ct);
    check("r0_passthru", ct, pt);

    // encrypt / decrypt round trips on the narrow engine
    for (int a = 0; a < 3; a++) begin
      run_job(0, pt, 3, 0, algs[a], 0, 0, 0, ct);
      run_job(0, ct, 3, 1, algs[a], 0, 0, 0, back);
      check("roundtrip_n128", back, pt);
    end

    // wide engine, stalled key delivery
    for (int a = 0; a < 3; a++) begin
      pt = rand256();
      run_job(1, pt, 4, 0, algs[a], 3, 0, 0, ct);
      run_job(1, ct, 4, 1, algs[a], 3, 0, 0, back);
      check("roundtrip_n256", back, pt);
    end

    // result back-pressure with a new job waiting
    run_job(1, rand256(), 2, 0, 3'b001, 0, 5, 1, ct);
    run_job(1, rand256(), 2, 1, 3'b011, 0, 0, 0, ct);

    // over-range round count is clamped
    run_job(1, rand256(), RMAX + 3, 0, 3'b010, 0, 0, 0, ct);

    // randomized jobs
    for (int j = 0; j < 14; j++)
      run_job($urandom_range(0, 1) == 1, rand256(), $urandom_range(0, RMAX + 2),
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 2),
              $urandom_range(0, 2), 0, ct);

    // reset in the middle of a job
    sel = 0;
    d_in_valid = 1; d_in_data = rand256(); d_rounds = 5; d_dec = 0; d_alg = 3'b000;
    @(negedge clk);
    d_in_valid = 0; d_rk_valid = 1; d_rk_data = keys[0];
    @(negedge clk);
    rst = 1; d_rk_valid = 0;
    @(negedge clk);
    check_reset("midrun_rst");
    rst = 0;
    @(negedge clk);
    run_job(0, rand256(), 2, 0, 3'b011, 0, 0, 0, ct);

`ifdef NLRE_ABORT_EN
    // abort while running: no result, back to idle
    sel = 1;
    d_in_valid = 1; d_in_data = rand256(); d_rounds = 5; d_dec = 0; d_alg = 3'b001;
    @(negedge clk);
    d_in_valid = 0; d_rk_valid = 1; d_rk_data = keys[0];
    @(negedge clk);
    d_abort = 1;
    @(negedge clk);
    d_abort = 0; d_rk_valid = 0;
    check("abort_in_ready", o_in_ready, 1);
    check("abort_rk_req", o_rk_req, 0);
    check("abort_out_valid", o_out_valid, 0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_output", o_out_valid, 0);
    end
    // abort in IDLE does not block an accept
    d_abort = 1; d_in_valid = 1; d_rounds = 0;
    @(negedge clk);
    d_abort = 0; d_in_valid = 0;
    check("abort_idle_accept", o_out_valid, 1);
    d_out_ready = 1;
    @(negedge clk);
    d_out_ready = 0;
    check("abort_idle_done", o_in_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
